td4_prog_loader: RTL and testbench

- UART program loader directly upstream of the TD4 core's 16x8 program memory.
- Receives a 16-byte program image over a serial line and writes byte n to memory address n.
- Holds the CPU in reset for the whole load and releases it when the image is complete.
- Removes the need to resynthesise to change the program; the core fetches from the memory this block fills.

---
 rtl/td4_prog_loader.sv | 195 +++++++++++++++++++
 tb/tb_td4_prog_loader.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/td4_prog_loader.sv
// td4_prog_loader: UART loader that fills the TD4 16x8 program memory and holds the CPU in reset meanwhile
//
// Ports:
//   clock     system clock
//   reset     synchronous active-high reset
//   rx        UART serial in (8N1, LSB first, idle high), asynchronous to clock
//   load_req  one-cycle pulse that starts or restarts a load
//   wr_en     program-memory write strobe, one cycle per byte
//   wr_addr   program-memory write address, holds last written value
//   wr_data   program-memory write data {Imm,OP}, holds last written value
//   cpu_hold  high while the CPU must stay in reset
//   busy      high while loading
//   done      one-cycle pulse on successful completion
//   err       sticky error flag (frame error, timeout, checksum mismatch)
//
// Optional feature macro: TD4_LOADER_CHECKSUM_EN
//   When defined, a 17th byte equal to the mod-256 sum of the image must follow
//   the 16 image bytes; it is never written to memory.
module td4_prog_loader #(
    parameter int CLKS_PER_BIT   = 434,
    parameter int TIMEOUT_CYCLES = 5000000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx,
    input  logic       load_req,
    output logic       wr_en,
    output logic [3:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       cpu_hold,
    output logic       busy,
    output logic       done,
    output logic       err
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] TIMEOUT_MAX = TW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {IDLE, LOAD, ERROR} ld_state_t;

    logic          rx_meta;
    logic          rx_sync;
    rx_state_t     rx_state;
    logic [CW-1:0] bit_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic          stop_tick;
    logic          byte_valid;
    logic          frame_err;
    ld_state_t     state;
    logic [4:0]    count;
    logic [TW-1:0] idle_cnt;
    logic          finish;
`ifdef TD4_LOADER_CHECKSUM_EN
    logic [7:0]    sum;
`endif

    // two-flop synchroniser, idles high so reset cannot fake a start bit
    always_ff @(posedge clock) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
        end
    end

    // byte_valid/frame_err are combinational on the stop-sample cycle so the
    // loader registers the write on that same edge (one clock to wr_en)
    assign stop_tick  = (rx_state == RX_STOP) && (bit_cnt == FULL_M1);
    assign byte_valid = stop_tick && rx_sync;
    assign frame_err  = stop_tick && !rx_sync;

    always_ff @(posedge clock) begin
        if (reset) begin
            rx_state <= RX_IDLE;
            bit_cnt  <= '0;
            bit_idx  <= '0;
            shift    <= '0;
        end else begin
            case (rx_state)
                RX_IDLE: begin
                    bit_cnt <= '0;
                    if (!rx_sync) rx_state <= RX_START;
                end
                RX_START: begin
                    if (bit_cnt == HALF_M1) begin
                        bit_cnt  <= '0;
                        bit_idx  <= '0;
                        rx_state <= rx_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        bit_cnt <= bit_cnt + CW'(1);
                    end
                end
                RX_DATA: begin
                    if (bit_cnt == FULL_M1) begin
                        bit_cnt <= '0;
                        shift   <= {rx_sync, shift[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) rx_state <= RX_STOP;
                    end else begin
                        bit_cnt <= bit_cnt + CW'(1);
                    end
                end
                RX_STOP: begin
                    if (bit_cnt == FULL_M1) begin
                        bit_cnt  <= '0;
                        rx_state <= RX_IDLE;
                    end else begin
                        bit_cnt <= bit_cnt + CW'(1);
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    // loader; finish marks the last accepted byte so release happens one cycle later
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            count    <= '0;
            idle_cnt <= '0;
            finish   <= 1'b0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            cpu_hold <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
`ifdef TD4_LOADER_CHECKSUM_EN
            sum      <= '0;
`endif
        end else begin
            wr_en <= 1'b0;
            done  <= 1'b0;
            if (load_req) begin
                state    <= LOAD;
                count    <= '0;
                idle_cnt <= '0;
                finish   <= 1'b0;
                cpu_hold <= 1'b1;
                busy     <= 1'b1;
                err      <= 1'b0;
`ifdef TD4_LOADER_CHECKSUM_EN
                sum      <= '0;
`endif
            end else if (state == LOAD) begin
                if (finish) begin
                    finish   <= 1'b0;
                    done     <= 1'b1;
                    cpu_hold <= 1'b0;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end else if (frame_err || idle_cnt == TIMEOUT_MAX) begin
                    state <= ERROR;
                    err   <= 1'b1;
                    busy  <= 1'b0;
                end else if (byte_valid) begin
                    idle_cnt <= '0;
`ifdef TD4_LOADER_CHECKSUM_EN
                    if (count[4]) begin
                        if (shift == sum) begin
                            finish <= 1'b1;
                        end else begin
                            state <= ERROR;
                            err   <= 1'b1;
                            busy  <= 1'b0;
                        end
                    end else begin
                        wr_en   <= 1'b1;
                        wr_addr <= count[3:0];
                        wr_data <= shift;
                        count   <= count + 5'd1;
                        sum     <= sum + shift;
                    end
`else
                    wr_en   <= 1'b1;
                    wr_addr <= count[3:0];
                    wr_data <= shift;
                    count   <= count + 5'd1;
                    finish  <= (count == 5'd15);
`endif
                end else begin
                    idle_cnt <= idle_cnt + TW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_td4_prog_loader.sv
// tb_td4_prog_loader: self-checking bench for td4_prog_loader (CLKS_PER_BIT=4, TIMEOUT_CYCLES=200)
module tb_td4_prog_loader;
    localparam int CPB = 4;
    localparam int TMO = 200;
    // stop-bit sample edge relative to the edge after which the start bit is driven:
    // 2 synchroniser flops, 1 detect, half a bit, 8 data bits, 1 stop bit
    localparam int LAT = 2 + 1 + CPB / 2 + 8 * CPB + CPB;
`ifdef TD4_LOADER_CHECKSUM_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset;
    logic       rx;
    logic       load_req;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic       cpu_hold;
    logic       busy;
    logic       done;
    logic       err;

    td4_prog_loader #(.CLKS_PER_BIT(CPB), .TIMEOUT_CYCLES(TMO)) dut (
        .clock(clock), .reset(reset), .rx(rx), .load_req(load_req),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .cpu_hold(cpu_hold), .busy(busy), .done(done), .err(err)
    );

    initial forever #5 clock = ~clock;

    typedef enum {M_IDLE, M_LOAD, M_ERR} mstate_t;
    typedef struct {int cyc; int addr; logic [7:0] data;} wr_t;

    wr_t        wq[$];
    int         dq[$];
    mstate_t    m_state = M_IDLE;
    int         m_cnt = 0;
    logic [7:0] m_sum = 0;
    int         m_last_bv = 0;
    logic [3:0] last_addr = 0;
    logic [7:0] last_data = 0;
    logic [7:0] img [16];
    int         wr_at [16];
    int         cyc = 0;
    int         n_vec = 0;
    int         n_err = 0;
    bit         chk_on = 1'b0;
    int         t1;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // model: decides each frame's effect up front and schedules the expected strobes
    task automatic send_byte(input logic [7:0] d, input bit stop = 1'b1);
        int ev;
        ev = cyc + LAT;
        if (m_state == M_LOAD) begin
            if (!stop) begin
                m_state = M_ERR;
            end else if (m_cnt < 16) begin
                wq.push_back('{ev, m_cnt, d});
                m_sum += d;
                m_cnt++;
                m_last_bv = ev;
                if (m_cnt == 16 && !CHK) begin
                    dq.push_back(ev + 1);
                    m_state = M_IDLE;
                end
            end else if (d == m_sum) begin
                dq.push_back(ev + 1);
                m_state = M_IDLE;
            end else begin
                m_state = M_ERR;
            end
        end
        rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            tick(CPB);
        end
        rx = stop;
        tick(CPB);
        rx = 1'b1;
        tick(6);
    endtask

    task automatic pulse_load();
        load_req = 1'b1;
        tick(1);
        load_req = 1'b0;
        m_state = M_LOAD;
        m_cnt = 0;
        m_sum = 0;
        chk("busy_after_req", busy, 1);
        chk("hold_after_req", cpu_hold, 1);
        chk("err_after_req", err, 0);
    endtask

    always @(negedge clock) begin
        wr_t e;
        bit  exp_wr;
        bit  exp_done;
        if (chk_on) begin
            exp_wr = wq.size() > 0 && wq[0].cyc == cyc;
            chk("wr_en", wr_en, exp_wr);
            if (exp_wr) begin
                e = wq.pop_front();
                chk("wr_addr", wr_addr, e.addr);
                chk("wr_data", wr_data, e.data);
                chk("hold_during_write", cpu_hold, 1);
                chk("busy_during_write", busy, 1);
                img[e.addr] = wr_data;
                wr_at[e.addr] = cyc;
                last_addr = 4'(e.addr);
                last_data = e.data;
            end else begin
                chk("wr_addr_hold", wr_addr, last_addr);
                chk("wr_data_hold", wr_data, last_data);
            end
            exp_done = dq.size() > 0 && dq[0] == cyc;
            chk("done", done, exp_done);
            if (exp_done) begin
                void'(dq.pop_front());
                chk("hold_at_done", cpu_hold, 0);
                chk("busy_at_done", busy, 0);
            end
        end
    end

    initial begin
        reset = 1'b1;
        rx = 1'b1;
        load_req = 1'b0;
        tick(3);
        chk_on = 1'b1;
        chk("rst_wr_en", wr_en, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_cpu_hold", cpu_hold, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        reset = 1'b0;
        tick(2);

        // full image
        pulse_load();
        t1 = cyc;
        send_byte(8'hAC);
        send_byte(8'h6C);
        send_byte(8'h9E);
        send_byte(8'h5E);
        for (int i = 0; i < 12; i++) send_byte(8'h00);
`ifdef TD4_LOADER_CHECKSUM_EN
        chk("busy_await_sum", busy, 1);
        chk("image_sum", m_sum, 8'h14);
        send_byte(m_sum);
`endif
        tick(2);
        chk("t1_hold_released", cpu_hold, 0);
        chk("t1_busy", busy, 0);
        chk("t1_err", err, 0);
        chk("t1_img0", img[0], 8'hAC);
        chk("t1_img1", img[1], 8'h6C);
        chk("t1_img2", img[2], 8'h9E);
        chk("t1_img3", img[3], 8'h5E);
        chk("t1_img15", img[15], 8'h00);
        chk("t1_first_latency", wr_at[0] - t1, 41);

        // byte with no load request is discarded
        send_byte(8'hFF);
        chk("t2_hold", cpu_hold, 0);
        chk("t2_busy", busy, 0);

        // framing error, then recovery
        pulse_load();
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h44, 1'b0);
        chk("t3_err", err, 1);
        chk("t3_hold", cpu_hold, 1);
        chk("t3_busy", busy, 0);
        send_byte(8'h55);
        pulse_load();
        send_byte(8'h5A);
        chk("t3_restart_img0", img[0], 8'h5A);

        // restart during LOAD, then inter-byte timeout
        pulse_load();
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        send_byte(8'h04);
        send_byte(8'h05);
        chk("t4_img4", img[4], 8'h05);
        while (cyc < m_last_bv + TMO) tick(1);
        chk("t4_err_before_timeout", err, 0);
        tick(1);
        chk("t4_err_at_timeout", err, 1);
        chk("t4_hold", cpu_hold, 1);
        chk("t4_busy", busy, 0);
        m_state = M_ERR;
        tick(49);

        // one-cycle glitch is not a start bit
        pulse_load();
        rx = 1'b0;
        tick(1);
        rx = 1'b1;
        tick(10);
        send_byte(8'h3C);
        chk("t5_img0", img[0], 8'h3C);

        // reset in the middle of a frame during a load
        rx = 1'b0;
        tick(10);
        rx = 1'b1;
        tick(5);
        rx = 1'b0;
        tick(3);
        reset = 1'b1;
        rx = 1'b1;
        tick(1);
        wq.delete();
        dq.delete();
        m_state = M_IDLE;
        last_addr = 0;
        last_data = 0;
        chk("t6_wr_en", wr_en, 0);
        chk("t6_wr_addr", wr_addr, 0);
        chk("t6_wr_data", wr_data, 0);
        chk("t6_cpu_hold", cpu_hold, 0);
        chk("t6_busy", busy, 0);
        chk("t6_done", done, 0);
        chk("t6_err", err, 0);
        reset = 1'b0;
        tick(60);
        chk("t6_hold_after", cpu_hold, 0);

        // uniform image, with checksum when enabled
        pulse_load();
        for (int i = 0; i < 16; i++) send_byte(8'h01);
`ifdef TD4_LOADER_CHECKSUM_EN
        chk("t7_busy_await_sum", busy, 1);
        send_byte(8'h10);
        chk("t7_sum_ok_err", err, 0);
        chk("t7_sum_ok_hold", cpu_hold, 0);
        pulse_load();
        for (int i = 0; i < 16; i++) send_byte(8'h01);
        send_byte(8'h11);
        chk("t7_sum_bad_err", err, 1);
        chk("t7_sum_bad_hold", cpu_hold, 1);
`else
        chk("t7_hold", cpu_hold, 0);
        chk("t7_err", err, 0);
`endif
        chk("t7_img15", img[15], 8'h01);
        tick(5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
